// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//                Holds the arbiter state encoding, the memory read latency
//                and a helper that sizes the debug starvation counter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Arbiter states: idle/issue, CPU read return, debug read return.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } arb_state_t;

    // Cycles from a read issue to valid mem_rdata. The *_RD states each
    // last exactly this long.
    localparam int unsigned c_mem_rd_latency = 1;

    // Counter width able to hold 0..max_wait. A zero limit still gets one
    // bit so the counter port never collapses to zero width.
    function automatic int unsigned cnt_width(input int unsigned max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_starve.sv
`default_nettype none
// ============================================================================
//  Module      : starve_counter
//  Description : Saturating count of consecutive arbitration losses of a
//                pending debug request. Saturates at MAX_WAIT; clear wins
//                over increment.
//  Ports       : clk      - clock
//                reset    - synchronous active-high reset
//                inc      - debug lost arbitration this cycle
//                clr      - debug was granted this cycle
//                at_limit - count has reached MAX_WAIT
//  Revision    : 1.0 - initial release
// ============================================================================
module starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CNT_W = cnt_width(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    // With MAX_WAIT = 0 the counter sits at 0 and at_limit is always set,
    // which hands every contended cycle to debug.
    assign at_limit = (r_count >= CNT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one data-memory port between the CPU load/store path
//                and a debug/loader port. CPU has priority; a pending debug
//                request wins once it has lost MAX_WAIT consecutive times.
//                Sequences the 1-cycle memory read latency and drives a
//                combinational CPU stall.
//  Ports       : clk, reset              - clock, sync active-high reset
//                cpu_req/we/addr/wdata/be - CPU access request
//                cpu_stall               - freeze PC/writeback (comb.)
//                cpu_rdata/cpu_rvalid    - CPU load return
//                dbg_req/we/addr/wdata/be - debug access request
//                dbg_gnt                 - debug accepted this cycle (comb.)
//                dbg_rdata/dbg_rvalid    - debug read return
//                mem_en/we/addr/wdata/be - memory command, word-aligned addr
//                mem_rdata               - memory read data, 1 cycle later
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [3:0]        dbg_be,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Clears addr[1:0]; byte selection is carried only by the enables.
    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic w_at_limit;
    logic w_cpu_win;
    logic w_dbg_win;
    logic w_cnt_inc;
    logic w_cnt_clr;

    // CPU keeps priority until a pending debug request has waited long
    // enough; only meaningful in IDLE.
    assign w_cpu_win = cpu_req && (!dbg_req || !w_at_limit);
    assign w_dbg_win = dbg_req && !w_cpu_win;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_cnt_inc),
        .clr      (w_cnt_clr),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every output is forced low while reset is held, so a reset landing in
    // a *_RD state drops the pending return without an rvalid pulse.
    always_comb begin
        w_next_state = r_state;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = '0;
        cpu_stall    = 1'b0;
        cpu_rdata    = '0;
        cpu_rvalid   = 1'b0;
        dbg_gnt      = 1'b0;
        dbg_rdata    = '0;
        dbg_rvalid   = 1'b0;

        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    if (w_cpu_win) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr & c_align_mask;
                        mem_wdata = cpu_wdata;
                        mem_be    = cpu_be;
                        // Stores finish in the issue cycle; loads wait for data.
                        cpu_stall = !cpu_we;
                        w_cnt_inc = dbg_req;
                        if (!cpu_we) begin
                            w_next_state = CPU_RD;
                        end
                    end else if (w_dbg_win) begin
                        mem_en    = 1'b1;
                        mem_we    = dbg_we;
                        mem_addr  = dbg_addr & c_align_mask;
                        mem_wdata = dbg_wdata;
                        mem_be    = dbg_be;
                        dbg_gnt   = 1'b1;
                        cpu_stall = cpu_req;
                        w_cnt_clr = 1'b1;
                        if (!dbg_we) begin
                            w_next_state = DBG_RD;
                        end
                    end
                end
                CPU_RD: begin
                    cpu_rdata    = mem_rdata;
                    cpu_rvalid   = 1'b1;
                    w_next_state = IDLE;
                end
                DBG_RD: begin
                    dbg_rdata    = mem_rdata;
                    dbg_rvalid   = 1'b1;
                    cpu_stall    = cpu_req;
                    w_next_state = IDLE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. A behavioural memory
//                answers the DUT's memory port; a reference model tracks the
//                pending read, the debug wait count and its own copy of
//                memory, and every cycle's outputs are compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [3:0]        dbg_be;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_be     (dbg_be),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural memory driven by the DUT ----------------
    logic [7:0] env_mem [0:255];

    function automatic logic [31:0] env_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {env_mem[8'(b + 8'd3)], env_mem[8'(b + 8'd2)], env_mem[8'(b + 8'd1)], env_mem[b]};
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) env_mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
            end
        end
        if (mem_en && !mem_we) mem_rdata <= env_word(mem_addr);
    end

    // ---------------- reference model ----------------
    // m_pend: 0 = nothing outstanding, 1 = CPU read returns, 2 = debug read returns.
    logic [7:0]  m_mem [0:255];
    int          m_pend = 0, n_pend = 0;
    int          m_wait = 0, n_wait = 0;
    logic [31:0] m_rd_word = '0, n_rd_word = '0;
    logic        n_wr = 1'b0;
    logic [31:0] n_wr_addr = '0, n_wr_data = '0;
    logic [3:0]  n_wr_be = '0;

    function automatic logic [31:0] m_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {m_mem[8'(b + 8'd3)], m_mem[8'(b + 8'd2)], m_mem[8'(b + 8'd1)], m_mem[b]};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'h00;
            m_mem[i]   = 8'h00;
        end
    end

    // Compare process: expected outputs from the current model state and
    // inputs, then the model's next state for the coming edge.
    always @(negedge clk) begin
        logic        e_men, e_mwe, e_stall, e_gnt, e_crv, e_drv;
        logic [31:0] e_maddr, e_mwd, e_crd, e_drd;
        logic [3:0]  e_mbe;
        logic        cpu_wins;
        e_men = 0; e_mwe = 0; e_stall = 0; e_gnt = 0; e_crv = 0; e_drv = 0;
        e_maddr = 0; e_mwd = 0; e_crd = 0; e_drd = 0; e_mbe = 0;
        n_pend = m_pend; n_wait = m_wait; n_rd_word = m_rd_word; n_wr = 0;

        if (reset) begin
            n_pend = 0;
            n_wait = 0;
        end else if (m_pend == 1) begin
            e_crv  = 1; e_crd = m_rd_word; n_pend = 0;
        end else if (m_pend == 2) begin
            e_drv  = 1; e_drd = m_rd_word; e_stall = cpu_req; n_pend = 0;
        end else begin
            cpu_wins = cpu_req && (!dbg_req || (m_wait < int'(MAX_WAIT)));
            if (cpu_wins || dbg_req) begin
                e_men   = 1;
                e_mwe   = cpu_wins ? cpu_we : dbg_we;
                e_maddr = (cpu_wins ? cpu_addr : dbg_addr) & 32'hFFFF_FFFC;
                e_mwd   = cpu_wins ? cpu_wdata : dbg_wdata;
                e_mbe   = cpu_wins ? cpu_be : dbg_be;
                if (e_mwe) begin
                    n_wr = 1; n_wr_addr = e_maddr; n_wr_data = e_mwd; n_wr_be = e_mbe;
                end else begin
                    n_pend    = cpu_wins ? 1 : 2;
                    n_rd_word = m_word(e_maddr);
                end
            end
            if (cpu_wins) begin
                e_stall = !cpu_we;
                if (dbg_req) n_wait = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
            end else if (dbg_req) begin
                e_gnt   = 1;
                e_stall = cpu_req;
                n_wait  = 0;
            end
        end

        check("mem_en", mem_en, e_men);
        check("cpu_stall", cpu_stall, e_stall);
        check("dbg_gnt", dbg_gnt, e_gnt);
        check("cpu_rvalid", cpu_rvalid, e_crv);
        check("dbg_rvalid", dbg_rvalid, e_drv);
        if (e_men) begin
            check("mem_we", mem_we, e_mwe);
            check("mem_addr", mem_addr, e_maddr);
            check("mem_be", mem_be, e_mbe);
            if (e_mwe) check("mem_wdata", mem_wdata, e_mwd);
        end
        if (e_crv) check("cpu_rdata", cpu_rdata, e_crd);
        if (e_drv) check("dbg_rdata", dbg_rdata, e_drd);
    end

    always @(posedge clk) begin
        m_pend    = n_pend;
        m_wait    = n_wait;
        m_rd_word = n_rd_word;
        if (n_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (n_wr_be[i]) m_mem[8'(n_wr_addr[7:0] + 8'(i))] = n_wr_data[8*i +: 8];
            end
        end
        n_wr = 0;
    end

    // ---------------- stimulus ----------------
    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_be = be;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
        dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = data; dbg_be = be;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_cpu(1, 0, 32'd12, 32'd0, 4'hF);
        set_dbg(1, 0, 32'd0, 32'd0, 4'hF);
        repeat (2) begin
            @(negedge clk);
            check("rst_mem_en", mem_en, 0);
            check("rst_cpu_stall", cpu_stall, 0);
            check("rst_dbg_gnt", dbg_gnt, 0);
            tick();
        end
        reset = 1'b0;
        set_cpu(0, 0, 0, 0, 0);
        set_dbg(0, 0, 0, 0, 0);
        tick();

        // CPU store, single-cycle, then memory contents.
        set_cpu(1, 1, 32'd12, 32'd4, 4'hF);
        @(negedge clk); check("t1_stall", cpu_stall, 0);
        tick();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_env_word12", env_word(32'd12), 32'h0000_0004);
        check("t1_model_word12", m_word(32'd12), 32'h0000_0004);
        tick();

        // CPU load with 1-cycle return.
        set_cpu(1, 0, 32'd12, 32'd0, 4'hF);
        @(negedge clk); check("t2_issue_stall", cpu_stall, 1);
        tick();
        @(negedge clk);
        check("t2_rvalid", cpu_rvalid, 1);
        check("t2_rdata", cpu_rdata, 32'd4);
        check("t2_stall", cpu_stall, 0);
        tick();

        // Starvation limit: CPU stores every cycle, debug write held.
        set_dbg(1, 1, 32'd0, 32'hDEAD_BEEF, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            set_cpu(1, 1, 32'(16 + 4 * k), 32'(k), 4'hF);
            @(negedge clk);
            if (k < 5) check("t3_gnt_low", dbg_gnt, 0);
            else begin
                check("t3_gnt_5th", dbg_gnt, 1);
                check("t3_stall_5th", cpu_stall, 1);
            end
            tick();
        end
        // Counter cleared: the stalled CPU store wins against the next debug read.
        set_dbg(1, 0, 32'd0, 32'd0, 4'hF);
        @(negedge clk); check("t3_cnt_cleared", dbg_gnt, 0);
        tick();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk); check("t4_rd_gnt", dbg_gnt, 1);
        tick();
        set_dbg(0, 0, 0, 0, 0);
        set_cpu(1, 0, 32'd0, 32'd0, 4'hF);
        @(negedge clk);
        check("t4_dbg_rvalid", dbg_rvalid, 1);
        check("t4_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
        check("t4_stall_in_dbg_rd", cpu_stall, 1);
        tick();
        tick();
        @(negedge clk); check("t4_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // Simultaneous first requests: CPU load vs debug half-word write.
        set_cpu(1, 0, 32'd12, 32'd0, 4'hF);
        set_dbg(1, 1, 32'd4, 32'h1122_3344, 4'b0011);
        @(negedge clk);
        check("t6_cpu_first", cpu_stall, 1);
        check("t6_gnt_low", dbg_gnt, 0);
        tick();
        @(negedge clk); check("t6_gnt_in_cpu_rd", dbg_gnt, 0);
        tick();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk); check("t6_dbg_gnt", dbg_gnt, 1);
        tick();
        set_dbg(0, 0, 0, 0, 0);

        // Unaligned addresses and byte lanes.
        set_cpu(1, 0, 32'd6, 32'd0, 4'hF);
        tick();
        @(negedge clk); check("lane_rd_hw", cpu_rdata, 32'h0000_3344);
        tick();
        set_cpu(1, 1, 32'd13, 32'h00AA_0000, 4'b0100);
        tick();
        set_cpu(1, 0, 32'd15, 32'd0, 4'hF);
        tick();
        @(negedge clk); check("lane_rd_byte", cpu_rdata, 32'h00AA_0004);
        tick();
        set_cpu(0, 0, 0, 0, 0);
        tick();

        // Reset in CPU_RD aborts the read.
        set_cpu(1, 0, 32'd12, 32'd0, 4'hF);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_no_rvalid", cpu_rvalid, 0);
        check("t5_mem_en", mem_en, 0);
        tick();
        reset = 1'b0;
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk); check("t5_idle_no_rvalid", cpu_rvalid, 0);
        tick();
        set_cpu(1, 0, 32'd12, 32'd0, 4'hF);
        @(negedge clk); check("t5_reissue_stall", cpu_stall, 1);
        tick();
        @(negedge clk); check("t5_reissue_rdata", cpu_rdata, 32'h00AA_0004);
        tick();
        set_cpu(0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the single-cycle CPU load/store path and a debug/loader port used by benches and the boot loader.
- Sits between the CPU datapath and the data memory, and sequences the memory's 1-cycle read latency.
- Drives a combinational stall that freezes PC and register writeback until the CPU access completes.
- Round-robin is replaced by CPU priority with a bounded debug starvation limit.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- MAX_WAIT, 4, max consecutive cycles a pending debug request may lose to the CPU.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU memory access this cycle (load or store).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data, little-endian lanes.
- cpu_be  in  4  byte enables; bit i = byte addr+i.
- cpu_stall  out  1  freeze PC/writeback this cycle (combinational).
- cpu_rdata  out  DATA_W  load data; valid when cpu_rvalid = 1.
- cpu_rvalid  out  1  load data valid; CPU commits this cycle.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be  in  1/1/ADDR_W/DATA_W/4  debug request, same meaning as the cpu_* inputs.
- dbg_gnt  out  1  debug request accepted this cycle (combinational).
- dbg_rdata  out  DATA_W  debug read data.
- dbg_rvalid  out  1  debug read data valid.
- mem_en, mem_we  out  1/1  memory port enable and write.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  4  byte enables.
- mem_rdata  in  DATA_W  read data, valid 1 cycle after a read issue.

Behaviour:
- States: IDLE, CPU_RD, DBG_RD.
- Reset:
  - State goes to IDLE and the wait counter to 0.
  - While reset = 1, every output is 0 (mem_en, cpu_stall, dbg_gnt, and both rvalid outputs).
  - Reset during CPU_RD or DBG_RD aborts the read; no rvalid pulse follows.
- IDLE arbitration:
  - The CPU wins if cpu_req = 1 and (dbg_req = 0 or wait_cnt < MAX_WAIT). Otherwise debug wins if dbg_req = 1.
  - If nothing is requested, mem_en = 0.
- CPU store: issued same cycle with mem_en = 1, mem_we = 1 and cpu_stall = 0 (single-cycle completion). State stays IDLE.
- CPU load:
  - Issue cycle: mem_en = 1, mem_we = 0, cpu_stall = 1, next state CPU_RD.
  - CPU_RD: cpu_rdata = mem_rdata, cpu_rvalid = 1, cpu_stall = 0, mem_en = 0, next state IDLE.
  - CPU inputs must be held stable from issue through CPU_RD; a stalled CPU does this naturally.
- Debug grant:
  - dbg_gnt = 1 in the issue cycle; the requester drops or advances its request the next cycle.
  - A debug write completes in one cycle. A debug read goes to DBG_RD, and dbg_rvalid = 1 with dbg_rdata = mem_rdata the following cycle.
  - If cpu_req = 1 during a debug issue or DBG_RD, cpu_stall = 1.
- Starvation counter:
  - Increments on each IDLE cycle where dbg_req = 1 and debug is not granted; saturates at MAX_WAIT.
  - Clears to 0 on dbg_gnt.
  - MAX_WAIT = 0 means debug always wins over the CPU.
- Back-to-back: after CPU_RD returns to IDLE, a new request may issue on the very next cycle (no bubble).
- Addresses:
  - addr[1:0] are ignored on mem_addr; byte lanes come only from be. No shifting of data.
  - Address wrap at 2^ADDR_W is the memory's concern; the arbiter passes addresses unchanged apart from alignment.
- No combinational path from mem_rdata to any request-side output except rdata.

Decomposition:
- Shared constants include: the state encodings (IDLE = 2'd0, CPU_RD = 2'd1, DBG_RD = 2'd2) and the memory read latency constant (1).
- One sub-module, starve_counter: saturating counter with inc/clr inputs, parameterised by MAX_WAIT, and an output at_limit.

Test Plan:
1. CPU store addr 12, wdata 32'd4, be 4'b1111, no debug -> cpu_stall = 0; memory bytes[12..15] = 4,0,0,0 after the edge.
2. CPU load addr 12 -> issue cycle cpu_stall = 1; next cycle cpu_rvalid = 1, cpu_rdata = 32'd4, cpu_stall = 0.
3. CPU requests every cycle, dbg_req held with MAX_WAIT = 4 -> dbg_gnt on the 5th cycle; cpu_stall = 1 that cycle; counter reads 0 afterwards.
4. Debug write addr 0, data 32'hDEADBEEF, then debug read addr 0 -> dbg_gnt both times; dbg_rvalid one cycle after the read grant with data 32'hDEADBEEF.
5. CPU load issued, reset asserted in CPU_RD -> no cpu_rvalid; all outputs 0; state IDLE after reset release.
6. Simultaneous first requests (CPU load, debug write) with wait_cnt = 0 -> CPU granted; counter = 1; debug granted in the cycle after CPU_RD unless the CPU requests again (it then waits up to MAX_WAIT).
